// File: rtl/ysyx_25040111_exu_sb.sv
// ysyx_25040111_exu_sb
// Scoreboarded execute stage. Decoded operations arrive over a valid/ready
// handshake; the ALU result (or a load's effective address) is computed in
// one cycle and registered toward the memory/write-back arbiter. A small
// per-register pending-write counter tracks outstanding loads so that
// dependent operations stall until the load's write-back is reported on one
// of the finish ports.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready     issue handshake (in_ready never looks at in_valid)
//   in_op, in_imm_sel       ALU operation, operand-2 select (imm vs rs2)
//   in_rd/rs1/rs2           register indices
//   in_rs1_val/rs2_val/imm  operand values
//   in_wen, in_load         op writes rd / op is a load (locks rd)
//   out_valid / out_ready   registered result handshake
//   out_res, out_rd, out_wen, out_load  registered result fields
//   fin_valid, fin_rd       load completion ports, port k at fin_rd[k*AW +: AW]
//   busy                    bit r set while register r has pending loads
module ysyx_25040111_exu_sb #(
  parameter int NREG      = 16,
  parameter int XLEN      = 32,
  parameter int CNTW      = 2,
  parameter int NFIN      = 1,
  parameter int WAW_STALL = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic                in_imm_sel,
  input  logic [AW-1:0]       in_rd,
  input  logic [AW-1:0]       in_rs1,
  input  logic [AW-1:0]       in_rs2,
  input  logic [XLEN-1:0]     in_rs1_val,
  input  logic [XLEN-1:0]     in_rs2_val,
  input  logic [XLEN-1:0]     in_imm,
  input  logic                in_wen,
  input  logic                in_load,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_res,
  output logic [AW-1:0]       out_rd,
  output logic                out_wen,
  output logic                out_load,
  input  logic [NFIN-1:0]     fin_valid,
  input  logic [NFIN*AW-1:0]  fin_rd,
  output logic [NREG-1:0]     busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  logic [CNTW-1:0] cnt      [NREG];
  logic [CNTW-1:0] cnt_next [NREG];

  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] op2;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;

  // Hazard detection only looks at the registered counters, so a finish
  // arriving this cycle does not release a dependent op until the next cycle.
  always_comb begin
    hazard = 1'b0;
    if (cnt[in_rs1] != '0)
      hazard = 1'b1;
    if (!in_imm_sel && (cnt[in_rs2] != '0))
      hazard = 1'b1;
    if (in_wen && (WAW_STALL != 0) && (cnt[in_rd] != '0))
      hazard = 1'b1;
    if (in_load && in_wen && (cnt[in_rd] == CNT_MAX))
      hazard = 1'b1;
  end

  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Loads always compute rs1 + imm regardless of the op field.
  always_comb begin
    op2     = in_imm_sel ? in_imm : in_rs2_val;
    shamt   = op2[SHW-1:0];
    alu_res = '0;
    if (in_load) begin
      alu_res = in_rs1_val + in_imm;
    end else begin
      case (in_op)
        OP_ADD:  alu_res = in_rs1_val + op2;
        OP_SUB:  alu_res = in_rs1_val - op2;
        OP_AND:  alu_res = in_rs1_val & op2;
        OP_OR:   alu_res = in_rs1_val | op2;
        OP_XOR:  alu_res = in_rs1_val ^ op2;
        OP_SLL:  alu_res = in_rs1_val << shamt;
        OP_SRL:  alu_res = in_rs1_val >> shamt;
        OP_SRA:  alu_res = $signed(in_rs1_val) >>> shamt;
        default: alu_res = '0;
      endcase
    end
  end

  // Counter update: add the issuing load, subtract every matching finish,
  // clamp at zero so stray finishes are harmless. Register 0 never locks.
  always_comb begin
    int acc;
    int dec;
    acc = 0;
    dec = 0;
    for (int r = 0; r < NREG; r++) begin
      dec = 0;
      for (int k = 0; k < NFIN; k++) begin
        if (fin_valid[k] && (fin_rd[k*AW +: AW] == AW'(r)))
          dec = dec + 1;
      end
      acc = int'(cnt[r]) - dec;
      if (accept && in_load && in_wen && (in_rd != '0) && (in_rd == AW'(r)))
        acc = acc + 1;
      if (acc < 0)
        acc = 0;
      cnt_next[r] = (r == 0) ? '0 : CNTW'(acc);
    end
  end

  // Scoreboard state; reset discards all outstanding locks immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= cnt_next[r];
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++)
      busy[r] = (cnt[r] != '0);
  end

  // Output register: an accept always overwrites (possibly while draining);
  // without an accept, a drain clears valid and the fields hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_rd    <= '0;
      out_wen   <= 1'b0;
      out_load  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_res   <= alu_res;
      out_rd    <= in_rd;
      out_wen   <= in_wen;
      out_load  <= in_load;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_exu_sb.sv
// Directed bench for ysyx_25040111_exu_sb. Instance "dut" uses the default
// parameters (WAW stall on, one finish port); instance "dutb" disables the
// WAW stall and has two finish ports so counter saturation and dual finishes
// can be exercised.
module tb_ysyx_25040111_exu_sb;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_SRA = 3'd7;

  logic        clock;
  logic        reset;

  logic        in_valid, in_ready, in_imm_sel, in_wen, in_load;
  logic [2:0]  in_op;
  logic [3:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic        out_valid, out_ready, out_wen, out_load;
  logic [31:0] out_res;
  logic [3:0]  out_rd;
  logic [0:0]  fin_valid;
  logic [3:0]  fin_rd;
  logic [15:0] busy;

  logic        b_in_valid, b_in_ready, b_in_imm_sel, b_in_wen, b_in_load;
  logic [2:0]  b_in_op;
  logic [3:0]  b_in_rd, b_in_rs1, b_in_rs2;
  logic [31:0] b_in_rs1_val, b_in_rs2_val, b_in_imm;
  logic        b_out_valid, b_out_ready, b_out_wen, b_out_load;
  logic [31:0] b_out_res;
  logic [3:0]  b_out_rd;
  logic [1:0]  b_fin_valid;
  logic [7:0]  b_fin_rd;
  logic [15:0] b_busy;

  int numChecks;
  int numBad;

  ysyx_25040111_exu_sb dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_imm_sel(in_imm_sel), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_wen(in_wen), .in_load(in_load),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_rd(out_rd), .out_wen(out_wen), .out_load(out_load),
    .fin_valid(fin_valid), .fin_rd(fin_rd), .busy(busy)
  );

  ysyx_25040111_exu_sb #(.WAW_STALL(0), .NFIN(2)) dutb (
    .clock(clock), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
    .in_imm_sel(b_in_imm_sel), .in_rd(b_in_rd), .in_rs1(b_in_rs1), .in_rs2(b_in_rs2),
    .in_rs1_val(b_in_rs1_val), .in_rs2_val(b_in_rs2_val), .in_imm(b_in_imm),
    .in_wen(b_in_wen), .in_load(b_in_load),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_res(b_out_res),
    .out_rd(b_out_rd), .out_wen(b_out_wen), .out_load(b_out_load),
    .fin_valid(b_fin_valid), .fin_rd(b_fin_rd), .busy(b_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something wedges the main sequence.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numBad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] op,
                               input logic imm_sel, input logic [3:0] rd,
                               input logic [3:0] rs1, input logic [3:0] rs2,
                               input logic [31:0] rs1_val, input logic [31:0] rs2_val,
                               input logic [31:0] imm, input logic wen,
                               input logic load);
    in_valid   = valid;
    in_op      = op;
    in_imm_sel = imm_sel;
    in_rd      = rd;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rs1_val = rs1_val;
    in_rs2_val = rs2_val;
    in_imm     = imm;
    in_wen     = wen;
    in_load    = load;
  endtask

  // Instance B only ever sees loads of x0 + imm into rd.
  task automatic applyStimulusB(input logic valid, input logic [3:0] rd,
                                input logic [31:0] imm);
    b_in_valid   = valid;
    b_in_op      = OP_ADD;
    b_in_imm_sel = 1'b1;
    b_in_rd      = rd;
    b_in_rs1     = 4'd0;
    b_in_rs2     = 4'd0;
    b_in_rs1_val = 32'h40;
    b_in_rs2_val = 32'h0;
    b_in_imm     = imm;
    b_in_wen     = 1'b1;
    b_in_load    = 1'b1;
  endtask

  logic [2:0]  tblOp  [5];
  logic [31:0] tblExp [5];

  initial begin
    numChecks = 0;
    numBad    = 0;
    reset     = 1'b0;
    out_ready = 1'b1;
    fin_valid = '0;
    fin_rd    = '0;
    applyStimulus(1'b0, OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    b_out_ready = 1'b1;
    b_fin_valid = '0;
    b_fin_rd    = '0;
    applyStimulusB(1'b0, 4'd0, 32'h0);

    // Reset state
    repeat (2) stepClock();
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_res", out_res, 32'h0);
    checkOutput("rst_busy", busy, 16'h0);
    checkOutput("rst_b_busy", b_busy, 16'h0);
    reset = 1'b1;
    #1;
    checkOutput("rst_in_ready", in_ready, 1'b1);

    // Back-to-back ALU ops
    applyStimulus(1'b1, OP_ADD, 1'b0, 4'd1, 4'd1, 4'd2, 32'd5, 32'd7, 32'h0, 1'b1, 1'b0);
    #1 checkOutput("b2b_ready0", in_ready, 1'b1);
    stepClock();
    checkOutput("b2b_valid0", out_valid, 1'b1);
    checkOutput("b2b_add", out_res, 32'd12);
    checkOutput("b2b_rd", out_rd, 4'd1);
    applyStimulus(1'b1, OP_SUB, 1'b0, 4'd1, 4'd1, 4'd2, 32'd3, 32'd5, 32'h0, 1'b1, 1'b0);
    #1 checkOutput("b2b_ready1", in_ready, 1'b1);
    stepClock();
    checkOutput("b2b_sub", out_res, 32'hFFFF_FFFE);
    applyStimulus(1'b1, OP_SRA, 1'b0, 4'd1, 4'd1, 4'd2, 32'h8000_0000, 32'd4, 32'h0, 1'b1, 1'b0);
    #1 checkOutput("b2b_ready2", in_ready, 1'b1);
    stepClock();
    checkOutput("b2b_sra", out_res, 32'hF800_0000);
    checkOutput("b2b_valid2", out_valid, 1'b1);

    // Remaining ops; shift amount uses only the low five bits of operand 2
    tblOp[0] = 3'd2; tblExp[0] = 32'h00F0_0004;
    tblOp[1] = 3'd3; tblExp[1] = 32'hFFF0_1235;
    tblOp[2] = 3'd4; tblExp[2] = 32'hFF00_1231;
    tblOp[3] = 3'd5; tblExp[3] = 32'h1E02_4680;
    tblOp[4] = 3'd6; tblExp[4] = 32'h0787_8091;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, tblOp[i], 1'b0, 4'd2, 4'd1, 4'd2, 32'hF0F0_1234,
                    32'h0FF0_0005, 32'h0, 1'b1, 1'b0);
      stepClock();
      checkOutput($sformatf("alu_op%0d", tblOp[i]), out_res, tblExp[i]);
    end
    applyStimulus(1'b1, OP_SRA, 1'b0, 4'd2, 4'd1, 4'd2, 32'hF0F0_1234,
                  32'h0FF0_0005, 32'h0, 1'b1, 1'b0);
    stepClock();
    checkOutput("alu_sra_neg", out_res, 32'hFF87_8091);
    applyStimulus(1'b0, OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    stepClock();
    checkOutput("idle_drain", out_valid, 1'b0);

    // Load then dependent ADD; the op field is ignored for loads
    applyStimulus(1'b1, OP_AND, 1'b1, 4'd3, 4'd1, 4'd0, 32'h100, 32'h0, 32'h8, 1'b1, 1'b1);
    stepClock();
    checkOutput("ld_addr", out_res, 32'h108);
    checkOutput("ld_flag", out_load, 1'b1);
    checkOutput("ld_busy", busy, 16'h0008);
    applyStimulus(1'b1, OP_ADD, 1'b0, 4'd6, 4'd3, 4'd2, 32'd10, 32'd20, 32'h0, 1'b1, 1'b0);
    #1 checkOutput("raw_stall", in_ready, 1'b0);
    stepClock();
    checkOutput("raw_drained", out_valid, 1'b0);
    checkOutput("raw_stall2", in_ready, 1'b0);
    fin_valid = 1'b1;
    fin_rd    = 4'd3;
    #1 checkOutput("fin_no_bypass", in_ready, 1'b0);
    stepClock();
    fin_valid = 1'b0;
    #1;
    checkOutput("fin_busy_clr", busy, 16'h0);
    checkOutput("fin_ready", in_ready, 1'b1);
    stepClock();
    checkOutput("raw_res", out_res, 32'd30);
    checkOutput("raw_rd", out_rd, 4'd6);

    // Backpressure
    applyStimulus(1'b1, OP_ADD, 1'b0, 4'd7, 4'd1, 4'd2, 32'd1, 32'd2, 32'h0, 1'b1, 1'b0);
    stepClock();
    checkOutput("bp_first", out_res, 32'd3);
    out_ready = 1'b0;
    applyStimulus(1'b1, OP_ADD, 1'b0, 4'd8, 4'd1, 4'd2, 32'd100, 32'd1, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("bp_ready", in_ready, 1'b0);
      checkOutput("bp_valid", out_valid, 1'b1);
      checkOutput("bp_res", out_res, 32'd3);
      checkOutput("bp_rd", out_rd, 4'd7);
      stepClock();
    end
    out_ready = 1'b1;
    #1 checkOutput("bp_release_ready", in_ready, 1'b1);
    stepClock();
    checkOutput("bp_next_res", out_res, 32'd101);
    checkOutput("bp_next_rd", out_rd, 4'd8);
    checkOutput("bp_next_valid", out_valid, 1'b1);

    // WAW stall and spurious finishes
    applyStimulus(1'b1, OP_ADD, 1'b1, 4'd4, 4'd1, 4'd0, 32'h200, 32'h0, 32'h4, 1'b1, 1'b1);
    stepClock();
    checkOutput("waw_busy", busy, 16'h0010);
    applyStimulus(1'b1, OP_ADD, 1'b1, 4'd4, 4'd1, 4'd0, 32'h200, 32'h0, 32'h11, 1'b1, 1'b0);
    #1 checkOutput("waw_stall", in_ready, 1'b0);
    fin_valid = 1'b1;
    fin_rd    = 4'd0;
    stepClock();
    checkOutput("fin_x0", busy, 16'h0010);
    fin_rd = 4'd9;
    stepClock();
    checkOutput("fin_idle_reg", busy, 16'h0010);
    fin_rd = 4'd4;
    stepClock();
    fin_valid = 1'b0;
    #1;
    checkOutput("waw_busy_clr", busy, 16'h0);
    checkOutput("waw_ready", in_ready, 1'b1);
    stepClock();
    checkOutput("waw_res", out_res, 32'h211);
    applyStimulus(1'b0, OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    stepClock();

    // Instance B: counter saturation with WAW stall off
    applyStimulusB(1'b1, 4'd5, 32'h4);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("b_load_ready", b_in_ready, 1'b1);
      stepClock();
    end
    #1;
    checkOutput("b_cnt_max_stall", b_in_ready, 1'b0);
    checkOutput("b_busy5", b_busy, 16'h0020);
    checkOutput("b_ld_addr", b_out_res, 32'h44);
    b_in_valid  = 1'b0;
    b_fin_valid = 2'b11;
    b_fin_rd    = {4'd5, 4'd5};
    stepClock();
    b_fin_valid = 2'b00;
    #1 checkOutput("b_dual_fin", b_busy, 16'h0020);
    b_fin_valid = 2'b10;
    stepClock();
    b_fin_valid = 2'b00;
    #1 checkOutput("b_fin_last", b_busy, 16'h0);

    // Instance B: load and finish on the same register in one cycle
    applyStimulusB(1'b1, 4'd4, 32'h0);
    stepClock();
    checkOutput("b_ld4_busy", b_busy, 16'h0010);
    b_fin_valid = 2'b01;
    b_fin_rd    = {4'd0, 4'd4};
    #1 checkOutput("b_ld4_again_ready", b_in_ready, 1'b1);
    stepClock();
    b_in_valid  = 1'b0;
    b_fin_valid = 2'b00;
    #1 checkOutput("b_inc_dec_net", b_busy, 16'h0010);
    b_fin_valid = 2'b01;
    stepClock();
    b_fin_valid = 2'b00;
    #1 checkOutput("b_fin4", b_busy, 16'h0);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    applyStimulus(1'b1, OP_ADD, 1'b1, 4'd3, 4'd1, 4'd0, 32'h100, 32'h0, 32'h8, 1'b1, 1'b1);
    stepClock();
    applyStimulus(1'b0, OP_ADD, 1'b0, 4'd0, 4'd1, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("pre_rst_valid", out_valid, 1'b1);
    checkOutput("pre_rst_busy", busy, 16'h0008);
    #1 reset = 1'b0;
    #1;
    checkOutput("async_rst_valid", out_valid, 1'b0);
    checkOutput("async_rst_busy", busy, 16'h0);
    checkOutput("async_rst_res", out_res, 32'h0);
    checkOutput("async_rst_ready", in_ready, 1'b1);
    stepClock();
    reset = 1'b1;
    stepClock();

    $display("test done: total=%0d bad=%0d", numChecks, numBad);
    $finish;
  end

endmodule
